// File: rtl/dbte_lookup_arbiter.sv
// ============================================================================
// Module  : dbte_lookup_arbiter
// Brief   : Round-robin arbiter sharing one single-beat DBTE AXI read master
//           between NUM_REQ lookup requesters. Optional R-wait timeout with
//           drain of the late beat is enabled by DBTE_LOOKUP_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dbte_lookup_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 48,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [ADDR_W-1:0]         m_axi_dbte_araddr,
  output logic [7:0]                m_axi_dbte_arlen,
  output logic [2:0]                m_axi_dbte_arsize,
  output logic [1:0]                m_axi_dbte_arburst,
  output logic                      m_axi_dbte_arvalid,
  input  logic                      m_axi_dbte_arready,
  input  logic [DATA_W-1:0]         m_axi_dbte_rdata,
  input  logic [1:0]                m_axi_dbte_rresp,
  input  logic                      m_axi_dbte_rlast,
  input  logic                      m_axi_dbte_rvalid,
  output logic                      m_axi_dbte_rready,
  output logic                      timeout_irq
);

  localparam int               IDX_W          = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [IDX_W-1:0] c_last_idx     = IDX_W'(NUM_REQ - 1);
  localparam logic [15:0]      c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_RWAIT = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_grant;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_arvalid;
  logic                r_rready;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic                r_resp_err;

`ifdef DBTE_LOOKUP_TIMEOUT_EN
  logic [15:0]         r_timeout_cnt;
  logic                r_timed_out;
  logic                r_timeout_irq;
`endif

  logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];
  logic                w_grant_found;
  logic [IDX_W-1:0]    w_grant_idx;
  logic [IDX_W-1:0]    w_rr_next;
  logic [NUM_REQ-1:0]  w_grant_onehot;
  logic [NUM_REQ-1:0]  w_held_onehot;
  logic                w_unused;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign w_addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // First requester at or above rr_ptr, wrapping past the top index.
  always_comb begin
    int j;
    j             = 0;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_grant_found && req_valid[j[IDX_W-1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = j[IDX_W-1:0];
      end
    end
  end

  assign w_rr_next      = (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + 1'b1;
  assign w_grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx;
  assign w_held_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;

  // Acceptance is combinational so the address is captured in the grant cycle.
  assign req_ready = (r_state == ST_IDLE && !reset && w_grant_found) ? w_grant_onehot : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_araddr     <= '0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
`ifdef DBTE_LOOKUP_TIMEOUT_EN
      r_timeout_cnt <= '0;
      r_timed_out   <= 1'b0;
      r_timeout_irq <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_found) begin
            r_grant   <= w_grant_idx;
            r_araddr  <= w_addr_arr[w_grant_idx];
            r_rr_ptr  <= w_rr_next;
            r_arvalid <= 1'b1;
            r_state   <= ST_AR;
          end
        end
        ST_AR: begin
          if (m_axi_dbte_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RWAIT;
`ifdef DBTE_LOOKUP_TIMEOUT_EN
            r_timeout_cnt <= '0;
`endif
          end
        end
        ST_RWAIT: begin
          if (m_axi_dbte_rvalid) begin
            r_rready     <= 1'b0;
            r_resp_data  <= m_axi_dbte_rdata;
            r_resp_err   <= (m_axi_dbte_rresp != 2'b00);
            r_resp_valid <= w_held_onehot;
            r_state      <= ST_RESP;
          end
`ifdef DBTE_LOOKUP_TIMEOUT_EN
          else if (r_timeout_cnt == c_timeout_last) begin
            // Slave never answered: fail the lookup, drain the beat later.
            r_rready      <= 1'b0;
            r_resp_data   <= '0;
            r_resp_err    <= 1'b1;
            r_resp_valid  <= w_held_onehot;
            r_timed_out   <= 1'b1;
            r_timeout_irq <= 1'b1;
            r_state       <= ST_RESP;
          end else begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
          end
`endif
        end
        ST_RESP: begin
          if (resp_ready[r_grant]) begin
            r_resp_valid <= '0;
`ifdef DBTE_LOOKUP_TIMEOUT_EN
            if (r_timed_out) begin
              r_timed_out <= 1'b0;
              r_rready    <= 1'b1;
              r_state     <= ST_DRAIN;
            end else begin
              r_state <= ST_IDLE;
            end
`else
            r_state <= ST_IDLE;
`endif
          end
        end
`ifdef DBTE_LOOKUP_TIMEOUT_EN
        ST_DRAIN: begin
          if (m_axi_dbte_rvalid) begin
            r_rready <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid         = r_resp_valid;
  assign resp_data          = r_resp_data;
  assign resp_err           = r_resp_err;
  assign m_axi_dbte_araddr  = r_araddr;
  assign m_axi_dbte_arlen   = 8'd0;
  assign m_axi_dbte_arsize  = 3'b100;
  assign m_axi_dbte_arburst = 2'b01;
  assign m_axi_dbte_arvalid = r_arvalid;
  assign m_axi_dbte_rready  = r_rready;

`ifdef DBTE_LOOKUP_TIMEOUT_EN
  assign timeout_irq = r_timeout_irq;
`else
  assign timeout_irq = 1'b0;
`endif

  // Single-beat reads make rlast redundant.
  assign w_unused = &{1'b0, m_axi_dbte_rlast, c_timeout_last};

endmodule

`default_nettype wire
